// File: rtl/caravel_clock_cfg_seq.sv
// Clock configuration sequencer: parks the core on ext_clk, applies new divider codes,
// waits for PLL lock and hands the core back. Optional status port under CLK_SEQ_STATUS_EN.
module caravel_clock_cfg_seq #(
   parameter int         SETTLE_CYCLES = 8,
   parameter int         LOCK_TIMEOUT  = 1024,
   parameter logic [2:0] RESET_SEL     = 3'd1
) (
   input  logic       core_clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_pll_en,
   input  logic [2:0] req_sel,
   input  logic [2:0] req_sel2,
   input  logic       pll_lock,
   output logic       ext_clk_sel,
   output logic [2:0] sel,
   output logic [2:0] sel2,
   output logic       busy,
   output logic       done,
`ifdef CLK_SEQ_STATUS_EN
   output logic       err,
   output logic [7:0] status
`else
   output logic       err
`endif
);

   localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   localparam logic [CW-1:0] SETTLE_FULL = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] SETTLE_END  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_END    = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] PLL_END     = CW'(2);
   localparam logic [CW-1:0] CNT_SAT     = '1;

   typedef enum logic [2:0] {
      IDLE,
      TO_EXT,
      APPLY,
      SETTLE,
      LOCK_WAIT,
      TO_PLL,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ext_q, ext_d;
   logic [2:0]    sel_q, sel_d;
   logic [2:0]    sel2_q, sel2_d;
   logic [2:0]    capSel_q, capSel_d;
   logic [2:0]    capSel2_q, capSel2_d;
   logic          capPll_q, capPll_d;
   logic          wasExt_q, wasExt_d;
   logic          noop_q, noop_d;
   logic          abort_q, abort_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          accept;
   logic          isNoop;

   assign accept = req_valid && (state_q == IDLE);
   assign isNoop = (req_sel == sel_q) && (req_sel2 == sel2_q) && (req_pll_en == ~ext_q);

   // Sequencing: the divider codes can only move in APPLY, which is reached only via TO_EXT.
   always_comb begin
      state_d   = state_q;
      ext_d     = ext_q;
      sel_d     = sel_q;
      sel2_d    = sel2_q;
      capSel_d  = capSel_q;
      capSel2_d = capSel2_q;
      capPll_d  = capPll_q;
      wasExt_d  = wasExt_q;
      noop_d    = noop_q;
      abort_d   = abort_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               capSel_d  = req_sel;
               capSel2_d = req_sel2;
               capPll_d  = req_pll_en;
               wasExt_d  = ext_q;
               noop_d    = isNoop;
               abort_d   = 1'b0;
               state_d   = isNoop ? DONE : TO_EXT;
            end
         end
         TO_EXT: begin
            ext_d = 1'b1;
            if (wasExt_q || (cnt_q == SETTLE_FULL)) begin
               state_d = APPLY;
            end
         end
         APPLY: begin
            sel_d   = capSel_q;
            sel2_d  = capSel2_q;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_END) begin
               state_d = capPll_q ? LOCK_WAIT : DONE;
            end
         end
         LOCK_WAIT: begin
            if (pll_lock) begin
               state_d = TO_PLL;
            end else if (cnt_q == LOCK_END) begin
               abort_d = 1'b1;
               state_d = DONE;
            end
         end
         // Two cycles after the switch cover the downstream two-flop mux synchroniser.
         TO_PLL: begin
            ext_d = 1'b0;
            if (cnt_q == PLL_END) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counter restarts on every state change and saturates rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign done_d = (state_q == DONE);
   assign err_d  = (state_q == DONE) && abort_q;

   always_ff @(posedge core_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ext_q     <= 1'b1;
         sel_q     <= RESET_SEL;
         sel2_q    <= RESET_SEL;
         capSel_q  <= RESET_SEL;
         capSel2_q <= RESET_SEL;
         capPll_q  <= 1'b0;
         wasExt_q  <= 1'b1;
         noop_q    <= 1'b0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ext_q     <= ext_d;
         sel_q     <= sel_d;
         sel2_q    <= sel2_d;
         capSel_q  <= capSel_d;
         capSel2_q <= capSel2_d;
         capPll_q  <= capPll_d;
         wasExt_q  <= wasExt_d;
         noop_q    <= noop_d;
         abort_q   <= abort_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef CLK_SEQ_STATUS_EN
   logic       timeout_q;
   logic [6:0] seqCount_q;

   // Aborted sequences still count as completed; no-op requests do not.
   always_ff @(posedge core_clk) begin
      if (reset) begin
         timeout_q  <= 1'b0;
         seqCount_q <= '0;
      end else begin
         if (err_d) begin
            timeout_q <= 1'b1;
         end
         if ((state_q == DONE) && !noop_q && (seqCount_q != 7'd127)) begin
            seqCount_q <= seqCount_q + 7'd1;
         end
      end
   end

   assign status = {timeout_q, seqCount_q};
`endif

   assign req_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign ext_clk_sel = ext_q;
   assign sel         = sel_q;
   assign sel2        = sel2_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_caravel_clock_cfg_seq.sv
// Directed testbench for caravel_clock_cfg_seq (SETTLE_CYCLES=8, LOCK_TIMEOUT=16).
// Cycle indices count edges after the accepting edge, sampled 1ns after each edge.
module tb_caravel_clock_cfg_seq;

   logic       core_clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       req_pll_en;
   logic [2:0] req_sel;
   logic [2:0] req_sel2;
   logic       pll_lock;
   logic       ext_clk_sel;
   logic [2:0] sel;
   logic [2:0] sel2;
   logic       busy;
   logic       done;
   logic       err;
`ifdef CLK_SEQ_STATUS_EN
   logic [7:0] status;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   caravel_clock_cfg_seq #(
      .SETTLE_CYCLES(8),
      .LOCK_TIMEOUT (16),
      .RESET_SEL    (3'd1)
   ) dut (
      .core_clk   (core_clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pll_en (req_pll_en),
      .req_sel    (req_sel),
      .req_sel2   (req_sel2),
      .pll_lock   (pll_lock),
      .ext_clk_sel(ext_clk_sel),
      .sel        (sel),
      .sel2       (sel2),
      .busy       (busy),
      .done       (done),
`ifdef CLK_SEQ_STATUS_EN
      .err        (err),
      .status     (status)
`else
      .err        (err)
`endif
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge core_clk);
      #1;
      cyc++;
   endtask

   task automatic stepTo(input int n);
      while (cyc < n) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One-cycle request pulse; cyc is 0 right after the accepting edge.
   task automatic applyStimulus(input logic pllEn, input logic [2:0] s, input logic [2:0] s2);
      req_pll_en = pllEn;
      req_sel    = s;
      req_sel2   = s2;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
      cyc        = 0;
   endtask

   initial begin
      int firstExt;
      int firstSel;
      int backPll;
      int firstDone;
      int readyHigh;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_pll_en = 1'b0;
      req_sel    = 3'd0;
      req_sel2   = 3'd0;
      pll_lock   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      checkOutput("rst_ext", ext_clk_sel, 1);
      checkOutput("rst_sel", sel, 1);
      checkOutput("rst_sel2", sel2, 1);
      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_busy", busy, 0);
`ifdef CLK_SEQ_STATUS_EN
      checkOutput("rst_status", status, 8'h00);
`endif

      // From ext clock to PLL with immediate lock
      pll_lock = 1'b1;
      applyStimulus(1'b1, 3'd4, 3'd2);
      checkOutput("t2_busy_e0", busy, 1);
      stepTo(1);
      checkOutput("t2_ready_e1", req_ready, 0);
      checkOutput("t2_sel_e1", sel, 1);
      stepTo(2);
      checkOutput("t2_sel_e2", sel, 4);
      checkOutput("t2_sel2_e2", sel2, 2);
      checkOutput("t2_ext_e2", ext_clk_sel, 1);
      stepTo(11);
      checkOutput("t2_ext_e11", ext_clk_sel, 1);
      stepTo(12);
      checkOutput("t2_ext_e12", ext_clk_sel, 0);
      stepTo(14);
      checkOutput("t2_done_e14", done, 0);
      stepTo(15);
      checkOutput("t2_done_e15", done, 1);
      checkOutput("t2_err_e15", err, 0);
      checkOutput("t2_busy_e15", busy, 0);
      stepTo(16);
      checkOutput("t2_done_e16", done, 0);

      // No-op request while on PLL
      applyStimulus(1'b1, 3'd4, 3'd2);
      stepTo(1);
      checkOutput("t4_done_e1", done, 1);
      checkOutput("t4_ext_e1", ext_clk_sel, 0);
      checkOutput("t4_sel_e1", sel, 4);
      checkOutput("t4_sel2_e1", sel2, 2);
      stepTo(2);
      checkOutput("t4_done_e2", done, 0);
      checkOutput("t4_busy_e2", busy, 0);

      // From PLL: must park on ext clock before the divider moves
      applyStimulus(1'b1, 3'd2, 3'd2);
      firstExt  = -1;
      firstSel  = -1;
      backPll   = -1;
      firstDone = -1;
      for (int i = 0; i < 40 && firstDone < 0; i++) begin
         tick();
         if (ext_clk_sel && firstExt < 0) firstExt = cyc;
         if (sel != 3'd4 && firstSel < 0) firstSel = cyc;
         if (!ext_clk_sel && firstExt >= 0 && backPll < 0) backPll = cyc;
         if (done && firstDone < 0) firstDone = cyc;
      end
      checkOutput("t5_first_ext", firstExt, 1);
      checkOutput("t5_first_sel", firstSel, 10);
      checkOutput("t5_back_pll", backPll, 20);
      checkOutput("t5_done", firstDone, 23);
      checkOutput("t5_sel_final", sel, 2);

      // Lock timeout: abort leaves the core on ext clock with new codes
      pll_lock = 1'b0;
      applyStimulus(1'b1, 3'd3, 3'd5);
      stepTo(34);
      checkOutput("t3_done_e34", done, 0);
      firstDone = -1;
      for (int i = 0; i < 30 && firstDone < 0; i++) begin
         if (done) firstDone = cyc;
         else tick();
      end
      checkOutput("t3_done_cycle", firstDone, 35);
      checkOutput("t3_err", err, 1);
      checkOutput("t3_ext", ext_clk_sel, 1);
      checkOutput("t3_sel", sel, 3);
      checkOutput("t3_sel2", sel2, 5);
`ifdef CLK_SEQ_STATUS_EN
      checkOutput("t3_status", status, 8'h83);
`endif
      tick();
      checkOutput("t3_err_clear", err, 0);

      // Reset in the middle of SETTLE
      pll_lock = 1'b1;
      applyStimulus(1'b0, 3'd6, 3'd6);
      stepTo(4);
      checkOutput("t6_sel_e4", sel, 6);
      checkOutput("t6_busy_e4", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t6_ext", ext_clk_sel, 1);
      checkOutput("t6_sel", sel, 1);
      checkOutput("t6_sel2", sel2, 1);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_ready", req_ready, 1);
`ifdef CLK_SEQ_STATUS_EN
      checkOutput("t6_status", status, 8'h00);
`endif

      // req_valid held through a sequence is not re-accepted until after done
      req_pll_en = 1'b0;
      req_sel    = 3'd5;
      req_sel2   = 3'd1;
      req_valid  = 1'b1;
      tick();
      cyc       = 0;
      readyHigh = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (req_ready) readyHigh++;
      end
      checkOutput("t6_ready_while_busy", readyHigh, 0);
      stepTo(11);
      checkOutput("t6_done_e11", done, 1);
      checkOutput("t6_ready_e11", req_ready, 1);
      checkOutput("t6_sel_e11", sel, 5);
      stepTo(12);
      checkOutput("t6_reaccept_busy", busy, 1);
      checkOutput("t6_done_e12", done, 0);
      stepTo(13);
      checkOutput("t6_noop_done", done, 1);
      req_valid = 1'b0;
      stepTo(14);
      checkOutput("t6_idle_busy", busy, 0);
      checkOutput("t6_idle_done", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
